pixel_write_arbiter: RTL and testbench

PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

---
 rtl/pixel_write_arbiter_if.sv | 46 ++++
 rtl/pixel_write_arbiter.sv | 124 ++++++++++++
 tb/tb_pixel_write_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_arbiter_if.sv
// Pixel-request bus between the player/obstacle renderers, the arbiter and the VGA adapter.
// master drives requests and hold; slave is the arbiter.
interface pixel_write_arbiter_if #(
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9
);
  logic [nX-1:0]          p_x;
  logic [nY-1:0]          p_y;
  logic [COLOR_DEPTH-1:0] p_color;
  logic                   p_write;
  logic                   p_ready;

  logic [nX-1:0]          o_x;
  logic [nY-1:0]          o_y;
  logic [COLOR_DEPTH-1:0] o_color;
  logic                   o_write;
  logic                   o_ready;

  logic                   hold;

  logic [nX-1:0]          VGA_x;
  logic [nY-1:0]          VGA_y;
  logic [COLOR_DEPTH-1:0] VGA_color;
  logic                   VGA_write;
  logic [7:0]             p_drops;
  logic [7:0]             o_drops;

  modport master (
    output p_x, p_y, p_color, p_write,
    output o_x, o_y, o_color, o_write,
    output hold,
    input  p_ready, o_ready,
    input  VGA_x, VGA_y, VGA_color, VGA_write,
    input  p_drops, o_drops
  );

  modport slave (
    input  p_x, p_y, p_color, p_write,
    input  o_x, o_y, o_color, o_write,
    input  hold,
    output p_ready, o_ready,
    output VGA_x, VGA_y, VGA_color, VGA_write,
    output p_drops, o_drops
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Two-source pixel write arbiter: per-source FIFOs, player priority with an obstacle
// anti-starvation streak, one registered VGA write per cycle.

module pwa_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          ready,
  output logic [7:0]    drops
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, drop;

  // ready comes from the registered count only, so a same-cycle pop never frees a slot
  assign ready = (count < CW'(DEPTH));
  assign push  = write & ready;
  assign drop  = write & ~ready;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drops  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop && drops != 8'hFF) drops <= drops + 8'd1;
    end
  end
endmodule

module pixel_write_arbiter #(
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9,
  parameter int DEPTH       = 4
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  pixel_write_arbiter_if.slave   bus
);
  localparam int W       = nX + nY + COLOR_DEPTH;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int NUM_SRC = 2;
  localparam logic [3:0] STREAK_MAX = 4'd8;

  // lane 0 = player, lane 1 = obstacle
  logic [NUM_SRC-1:0][W-1:0]  din, head;
  logic [NUM_SRC-1:0][CW-1:0] cnt;
  logic [NUM_SRC-1:0][7:0]    drops;
  logic [NUM_SRC-1:0]         wr, rdy, ne, pop;
  logic [3:0]                 streak;
  logic [W-1:0]               vga_px;
  logic                       vga_write;

  assign din[0] = {bus.p_x, bus.p_y, bus.p_color};
  assign din[1] = {bus.o_x, bus.o_y, bus.o_color};
  assign wr     = {bus.o_write, bus.p_write};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    pwa_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (Clock),
      .rst_n (Resetn),
      .write (wr[g]),
      .pop   (pop[g]),
      .din   (din[g]),
      .head  (head[g]),
      .count (cnt[g]),
      .ready (rdy[g]),
      .drops (drops[g])
    );
    assign ne[g] = (cnt[g] != '0);
  end

  assign bus.p_ready = rdy[0];
  assign bus.o_ready = rdy[1];
  assign bus.p_drops = drops[0];
  assign bus.o_drops = drops[1];

  // Player wins unless it is empty or has taken 8 grants in a row while obstacles waited
  always_comb begin
    pop = '0;
    if (!bus.hold) begin
      if (ne[1] && (streak == STREAK_MAX || !ne[0])) pop[1] = 1'b1;
      else if (ne[0])                                pop[0] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)               streak <= '0;
    else if (!ne[1] || pop[1]) streak <= '0;
    else if (pop[0])           streak <= streak + 4'd1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vga_px    <= '0;
      vga_write <= 1'b0;
    end else begin
      vga_write <= |pop;
      if (|pop) vga_px <= pop[1] ? head[1] : head[0];
    end
  end

  assign {bus.VGA_x, bus.VGA_y, bus.VGA_color} = vga_px;
  assign bus.VGA_write = vga_write;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: directed vector table with hand-derived flags plus a
// per-source queue scoreboard checking every output pixel and status each cycle.
module tb_pixel_write_arbiter;
  localparam int nX = 10, nY = 9, CD = 9, DEPTH = 4, NV = 26;

  typedef struct packed {
    logic [nX-1:0] x;
    logic [nY-1:0] y;
    logic [CD-1:0] c;
  } pix_t;

  typedef struct {
    bit   pw;  pix_t pp;
    bit   ow;  pix_t op;
    bit   hold;
    bit   ew;  bit epr; bit eor;
    int   epd; int eod;
  } vec_t;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;

  pixel_write_arbiter_if #(.nX(nX), .nY(nY), .COLOR_DEPTH(CD)) bus ();

  pixel_write_arbiter #(.nX(nX), .nY(nY), .COLOR_DEPTH(CD), .DEPTH(DEPTH)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  always #5 Clock = ~Clock;

  int   n_chk = 0, n_fail = 0;
  pix_t pq[$], oq[$];
  int   streak, m_pd, m_od;
  bit   m_w;
  pix_t m_out;
  vec_t tv[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete(); oq.delete();
    streak = 0; m_pd = 0; m_od = 0; m_w = 1'b0; m_out = '0;
  endtask

  task automatic drive(input bit pw, input pix_t pp, input bit ow, input pix_t op, input bit h);
    bus.p_write = pw; bus.p_x = pp.x; bus.p_y = pp.y; bus.p_color = pp.c;
    bus.o_write = ow; bus.o_x = op.x; bus.o_y = op.y; bus.o_color = op.c;
    bus.hold    = h;
  endtask

  // Drive one cycle, advance the scoreboard across the edge, compare everything
  task automatic cycle(input bit pw, input pix_t pp, input bit ow, input pix_t op, input bit h);
    bit pr, orr, o_ne, pop_o, pop_p;
    drive(pw, pp, ow, op, h);
    pr    = pq.size() < DEPTH;
    orr   = oq.size() < DEPTH;
    o_ne  = oq.size() > 0;
    pop_o = !h && o_ne && (streak == 8 || pq.size() == 0);
    pop_p = !h && !pop_o && pq.size() > 0;
    @(posedge Clock); #1;
    if (!o_ne || pop_o) streak = 0;
    else if (pop_p)     streak++;
    m_w = pop_o || pop_p;
    if (pop_o)      m_out = oq.pop_front();
    else if (pop_p) m_out = pq.pop_front();
    if (pw) begin
      if (pr) pq.push_back(pp);
      else if (m_pd < 255) m_pd++;
    end
    if (ow) begin
      if (orr) oq.push_back(op);
      else if (m_od < 255) m_od++;
    end
    chk("sb_write",   32'(bus.VGA_write), 32'(m_w));
    chk("sb_x",       32'(bus.VGA_x),     32'(m_out.x));
    chk("sb_y",       32'(bus.VGA_y),     32'(m_out.y));
    chk("sb_color",   32'(bus.VGA_color), 32'(m_out.c));
    chk("sb_p_ready", 32'(bus.p_ready),   32'(pq.size() < DEPTH));
    chk("sb_o_ready", 32'(bus.o_ready),   32'(oq.size() < DEPTH));
    chk("sb_p_drops", 32'(bus.p_drops),   32'(m_pd));
    chk("sb_o_drops", 32'(bus.o_drops),   32'(m_od));
  endtask

  function automatic vec_t mkv(bit pw, pix_t pp, bit ow, pix_t op, bit h,
                               bit ew, bit epr, bit eor, int epd, int eod);
    vec_t v;
    v.pw = pw; v.pp = pp; v.ow = ow; v.op = op; v.hold = h;
    v.ew = ew; v.epr = epr; v.eor = eor; v.epd = epd; v.eod = eod;
    return v;
  endfunction

  function automatic pix_t px(int x, int y, int c);
    pix_t p;
    p.x = nX'(x); p.y = nY'(y); p.c = CD'(c);
    return p;
  endfunction

  initial begin
    pix_t z, a;
    logic [31:0] ord;
    int n_out;
    z = '0;
    a = px(100, 50, 'h1FF);

    // single player pixel, then idle
    tv[0] = mkv(1, a, 0, z, 0, 0, 1, 1, 0, 0);
    tv[1] = mkv(0, z, 0, z, 0, 1, 1, 1, 0, 0);
    tv[2] = mkv(0, z, 0, z, 0, 0, 1, 1, 0, 0);
    // six pushes under hold: four queue, two drop
    for (int k = 0; k < 6; k++)
      tv[3+k] = mkv(1, px(16+k, k+1, 'h100+k), 0, z, 1, 0, k < 3, 1, (k < 4) ? 0 : k - 3, 0);
    for (int k = 0; k < 4; k++)
      tv[9+k] = mkv(0, z, 0, z, 0, 1, 1, 1, 2, 0);
    tv[13] = mkv(0, z, 0, z, 0, 0, 1, 1, 2, 0);
    // build count 3, then push+pop together twice
    for (int k = 0; k < 3; k++)
      tv[14+k] = mkv(1, px(40+k, 7, 'h0A0+k), 0, z, 1, 0, 1, 1, 2, 0);
    tv[17] = mkv(1, px(43, 7, 'h0A3), 0, z, 0, 1, 1, 1, 2, 0);
    tv[18] = mkv(1, px(44, 7, 'h0A4), 0, z, 0, 1, 1, 1, 2, 0);
    for (int k = 0; k < 3; k++)
      tv[19+k] = mkv(0, z, 0, z, 0, 1, 1, 1, 2, 0);
    tv[22] = mkv(0, z, 0, z, 0, 0, 1, 1, 2, 0);
    // single obstacle pixel
    tv[23] = mkv(0, z, 1, px('h3AB, 300, 'h055), 0, 0, 1, 1, 2, 0);
    tv[24] = mkv(0, z, 0, z, 0, 1, 1, 1, 2, 0);
    tv[25] = mkv(0, z, 0, z, 0, 0, 1, 1, 2, 0);

    drive(0, z, 0, z, 0);
    model_reset();
    #12;
    chk("rst_write",   32'(bus.VGA_write), 0);
    chk("rst_x",       32'(bus.VGA_x),     0);
    chk("rst_color",   32'(bus.VGA_color), 0);
    chk("rst_p_ready", 32'(bus.p_ready),   1);
    chk("rst_o_ready", 32'(bus.o_ready),   1);
    chk("rst_o_drops", 32'(bus.o_drops),   0);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    for (int i = 0; i < NV; i++) begin
      cycle(tv[i].pw, tv[i].pp, tv[i].ow, tv[i].op, tv[i].hold);
      chk($sformatf("vec%0d_write", i),   32'(bus.VGA_write), 32'(tv[i].ew));
      chk($sformatf("vec%0d_p_ready", i), 32'(bus.p_ready),   32'(tv[i].epr));
      chk($sformatf("vec%0d_o_ready", i), 32'(bus.o_ready),   32'(tv[i].eor));
      chk($sformatf("vec%0d_p_drops", i), 32'(bus.p_drops),   32'(tv[i].epd));
      chk($sformatf("vec%0d_o_drops", i), 32'(bus.o_drops),   32'(tv[i].eod));
    end
    chk("single_x", 32'(tv[0].pp.x), 100);

    // both sources every cycle for 20 cycles: player x[9]=0, obstacle x[9]=1
    ord = '0; n_out = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, px(i, 1, i), 1, px('h200 + i, 2, 'h1F0 - i), 0);
      if (bus.VGA_write) begin
        ord = {ord[30:0], bus.VGA_x[nX-1]};
        n_out++;
      end
    end
    chk("burst_outputs", 32'(n_out), 19);
    chk("burst_order",   ord, 32'h0000_0402);
    chk("burst_o_ready", 32'(bus.o_ready), 0);
    chk("burst_o_drops", 32'(bus.o_drops), 14);
    chk("burst_p_drops", 32'(bus.p_drops), 2);
    for (int i = 0; i < 10; i++) cycle(0, z, 0, z, 0);

    // obstacle drop counter saturation under hold
    for (int i = 0; i < 304; i++) cycle(0, z, 1, px('h2C0 + (i % 4), 11, 'h033), 1);
    chk("sat_o_drops", 32'(bus.o_drops), 255);
    for (int i = 0; i < 6; i++) cycle(0, z, 0, z, 0);

    // async reset with both FIFOs full
    for (int i = 0; i < 4; i++) cycle(1, px(500 + i, 3, 'h111), 1, px('h280 + i, 4, 'h122), 1);
    chk("full_p_ready", 32'(bus.p_ready), 0);
    drive(0, z, 0, z, 0);
    #3 Resetn = 1'b0;
    #1;
    chk("arst_write",   32'(bus.VGA_write), 0);
    chk("arst_x",       32'(bus.VGA_x),     0);
    chk("arst_y",       32'(bus.VGA_y),     0);
    chk("arst_p_ready", 32'(bus.p_ready),   1);
    chk("arst_o_ready", 32'(bus.o_ready),   1);
    chk("arst_o_drops", 32'(bus.o_drops),   0);
    model_reset();
    @(posedge Clock); #2;
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, z, 0, z, 0);
      chk("no_stale_write", 32'(bus.VGA_write), 0);
    end

    // push on the very first edge after reset release
    Resetn = 1'b0;
    #2;
    model_reset();
    Resetn = 1'b1;
    cycle(1, px(7, 8, 'h09C), 0, z, 0);
    cycle(0, z, 0, z, 0);
    chk("first_push_write", 32'(bus.VGA_write), 1);
    chk("first_push_x",     32'(bus.VGA_x),     7);
    chk("first_push_color", 32'(bus.VGA_color), 'h09C);
    cycle(0, z, 0, z, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
